// File: rtl/mem_wb_stage_buffer.sv
// MEM->WB boundary: 2-entry skid buffer (main + skid) with valid/ready flow control and flush.
// Optional back-pressure counter is enabled by defining MEMWB_STALL_CNT_EN.
module mem_wb_stage_buffer #(
  parameter int SCALAR_W = 16,
  parameter int VLANES   = 8,
  parameter int RADDR_W  = 5,
  parameter int SEL_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_wre,
  input  logic                         in_vwre,
  input  logic [SEL_W-1:0]             in_sel,
  input  logic [SEL_W-1:0]             in_vsel,
  input  logic [SCALAR_W-1:0]          in_mem_data,
  input  logic [VLANES*SCALAR_W-1:0]   in_vmem_data,
  input  logic [SCALAR_W-1:0]          in_calc_data,
  input  logic [VLANES*SCALAR_W-1:0]   in_calc_vec,
  input  logic [RADDR_W-1:0]           in_rs1,
  input  logic [RADDR_W-1:0]           in_rs2,
  input  logic [RADDR_W-1:0]           in_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_wre,
  output logic                         out_vwre,
  output logic [SEL_W-1:0]             out_sel,
  output logic [SEL_W-1:0]             out_vsel,
  output logic [SCALAR_W-1:0]          out_mem_data,
  output logic [VLANES*SCALAR_W-1:0]   out_vmem_data,
  output logic [SCALAR_W-1:0]          out_calc_data,
  output logic [VLANES*SCALAR_W-1:0]   out_calc_vec,
  output logic [RADDR_W-1:0]           out_rs1,
  output logic [RADDR_W-1:0]           out_rs2,
  output logic [RADDR_W-1:0]           out_rd,
  output logic [15:0]                  stall_cnt
);

  localparam int VW = VLANES * SCALAR_W;
  localparam int PW = 2 + 2*SEL_W + 2*SCALAR_W + 2*VW + 3*RADDR_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_pl;
  logic            main_wre, main_vwre;
  logic            accept, pop;

  assign in_pl = {in_wre, in_vwre, in_sel, in_vsel, in_mem_data, in_vmem_data,
                  in_calc_data, in_calc_vec, in_rs1, in_rs2, in_rd};

  // Handshake flags come from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_pl;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {main_wre, main_vwre, out_sel, out_vsel, out_mem_data, out_vmem_data,
          out_calc_data, out_calc_vec, out_rs1, out_rs2, out_rd} = main_q;

  // Write enables are gated so a bubble never writes the regfile, whatever stale payload it holds.
  assign out_wre  = main_wre  & out_valid;
  assign out_vwre = main_vwre & out_valid;

`ifdef MEMWB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 16'h0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_buffer.sv
// Testbench for mem_wb_stage_buffer: directed scenarios plus randomized traffic vs a queue model.
// Counter expectations follow MEMWB_STALL_CNT_EN when it is defined for the build.
module tb_mem_wb_stage_buffer;

  localparam int SCALAR_W = 16;
  localparam int VLANES   = 8;
  localparam int RADDR_W  = 5;
  localparam int SEL_W    = 2;
  localparam int VW       = VLANES * SCALAR_W;
  localparam int BW       = 2*SEL_W + 2*SCALAR_W + 2*VW + 3*RADDR_W;
`ifdef MEMWB_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic                wre;
    logic                vwre;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    vsel;
    logic [SCALAR_W-1:0] mem;
    logic [VW-1:0]       vmem;
    logic [SCALAR_W-1:0] calc;
    logic [VW-1:0]       cvec;
    logic [RADDR_W-1:0]  rs1;
    logic [RADDR_W-1:0]  rs2;
    logic [RADDR_W-1:0]  rd;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_wre = 1'b0, in_vwre = 1'b0;
  logic [SEL_W-1:0] in_sel = '0, in_vsel = '0;
  logic [SCALAR_W-1:0] in_mem_data = '0, in_calc_data = '0;
  logic [VW-1:0] in_vmem_data = '0, in_calc_vec = '0;
  logic [RADDR_W-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;

  logic in_ready, out_valid, out_wre, out_vwre;
  logic [SEL_W-1:0] out_sel, out_vsel;
  logic [SCALAR_W-1:0] out_mem_data, out_calc_data;
  logic [VW-1:0] out_vmem_data, out_calc_vec;
  logic [RADDR_W-1:0] out_rs1, out_rs2, out_rd;
  logic [15:0] stall_cnt;
  logic [BW-1:0] out_bus;

  int checks = 0;
  int errors = 0;
  txn_t model_q[$];
  int model_stall = 0;

  mem_wb_stage_buffer #(.SCALAR_W(SCALAR_W), .VLANES(VLANES), .RADDR_W(RADDR_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wre(in_wre), .in_vwre(in_vwre), .in_sel(in_sel), .in_vsel(in_vsel),
    .in_mem_data(in_mem_data), .in_vmem_data(in_vmem_data), .in_calc_data(in_calc_data),
    .in_calc_vec(in_calc_vec), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_wre(out_wre), .out_vwre(out_vwre),
    .out_sel(out_sel), .out_vsel(out_vsel), .out_mem_data(out_mem_data),
    .out_vmem_data(out_vmem_data), .out_calc_data(out_calc_data), .out_calc_vec(out_calc_vec),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .stall_cnt(stall_cnt)
  );

  assign out_bus = {out_sel, out_vsel, out_mem_data, out_vmem_data, out_calc_data,
                    out_calc_vec, out_rs1, out_rs2, out_rd};

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] exp_bus(input txn_t t);
    return {t.sel, t.vsel, t.mem, t.vmem, t.calc, t.cvec, t.rs1, t.rs2, t.rd};
  endfunction

  function automatic int exp_stall();
    return CNT_EN ? model_stall : 0;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wre  = 1'($urandom);
    t.vwre = 1'($urandom);
    t.sel  = SEL_W'($urandom);
    t.vsel = SEL_W'($urandom);
    t.mem  = SCALAR_W'($urandom);
    t.vmem = VW'({$urandom, $urandom, $urandom, $urandom});
    t.calc = SCALAR_W'($urandom);
    t.cvec = VW'({$urandom, $urandom, $urandom, $urandom});
    t.rs1  = RADDR_W'($urandom);
    t.rs2  = RADDR_W'($urandom);
    t.rd   = RADDR_W'($urandom);
    return t;
  endfunction

  function automatic txn_t rd_txn(input int rd, input int calc);
    txn_t t = rand_txn();
    t.wre  = 1'b1;
    t.rd   = RADDR_W'(rd);
    t.calc = SCALAR_W'(calc);
    return t;
  endfunction

  task automatic drive(input txn_t t, input logic v);
    in_valid = v;       in_wre = t.wre;        in_vwre = t.vwre;
    in_sel = t.sel;     in_vsel = t.vsel;      in_mem_data = t.mem;
    in_vmem_data = t.vmem; in_calc_data = t.calc; in_calc_vec = t.cvec;
    in_rs1 = t.rs1;     in_rs2 = t.rs2;        in_rd = t.rd;
  endtask

  // Advance one clock and apply the queue model: a 2-deep FIFO whose ready depends on prior occupancy.
  task automatic clock_cycle();
    txn_t t;
    bit acc, pp, stalled;
    t.wre = in_wre; t.vwre = in_vwre; t.sel = in_sel; t.vsel = in_vsel;
    t.mem = in_mem_data; t.vmem = in_vmem_data; t.calc = in_calc_data;
    t.cvec = in_calc_vec; t.rs1 = in_rs1; t.rs2 = in_rs2; t.rd = in_rd;
    acc     = in_valid && (model_q.size() < 2) && !flush;
    pp      = (model_q.size() > 0) && out_ready && !flush;
    stalled = (model_q.size() > 0) && !out_ready;
    @(posedge clk);
    #1;
    if (stalled && model_stall < 65535) model_stall++;
    if (flush) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(t);
    end
  endtask

  task automatic do_reset();
    txn_t z = '{default: '0};
    drive(z, 1'b0);
    flush = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #10;
    reset = 1'b0;
    model_q.delete();
    model_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wre !== 1'b0 || out_vwre !== 1'b0 ||
        stall_cnt !== 16'h0 || out_bus !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b wre=%b vwre=%b stall=%0d bus_zero=%b, required 0 1 0 0 0 1",
               out_valid, in_ready, out_wre, out_vwre, stall_cnt, out_bus == '0);
    end
    drive(rd_txn(1, 16'h11), 1'b1);
    clock_cycle();
    drive(rd_txn(2, 16'h22), 1'b1);
    clock_cycle();
    drive(rd_txn(3, 16'h33), 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_wre !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: valid=%b wre=%b ready=%b stall=%0d, required 0 0 1 0",
               out_valid, out_wre, in_ready, stall_cnt);
    end
    #6;
    reset = 1'b0;
    model_q.delete();
    model_stall = 0;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(rd_txn(i, 16'h1000 + i), 1'b1);
      clock_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_rd !== RADDR_W'(i) || out_calc_data !== SCALAR_W'(16'h1000 + i) ||
          in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b rd=%0d calc=%h ready=%b, required 1 %0d %h 1",
                 i, out_valid, out_rd, out_calc_data, in_ready, i, 16'h1000 + i);
      end
    end
    drive(rd_txn(0, 0), 1'b0);
    clock_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b, required 0", out_valid);
    end
    $display("test_stream done");
  endtask

  task automatic test_back_pressure();
    int got[$];
    int sent;
    do_reset();
    drive(rd_txn(3, 3), 1'b1);
    clock_cycle();
    drive(rd_txn(4, 4), 1'b1);
    clock_cycle();
    drive(rd_txn(5, 5), 1'b1);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== RADDR_W'(3)) begin
        errors++;
        $display("FAIL bp_hold_%0d: ready=%b valid=%b rd=%0d, required 0 1 3", c, in_ready, out_valid, out_rd);
      end
      clock_cycle();
    end
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) got.push_back(int'(out_rd));
      if (sent == 0 && model_q.size() < 2) sent = 1;
      clock_cycle();
      if (sent == 1) begin
        drive(rd_txn(0, 0), 1'b0);
        sent = 2;
      end
    end
    checks++;
    if (got.size() != 3 || got[0] != 3 || got[1] != 4 || got[2] != 5) begin
      errors++;
      $display("FAIL bp_order: got %0d entries %p, required 3 entries 3,4,5", got.size(), got);
    end
    $display("test_back_pressure done");
  endtask

  task automatic test_flush();
    do_reset();
    drive(rd_txn(7, 7), 1'b1);
    clock_cycle();
    drive(rd_txn(8, 8), 1'b1);
    clock_cycle();
    drive(rd_txn(9, 9), 1'b1);
    flush = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: valid=%b ready=%b, required 1 0", out_valid, in_ready);
    end
    clock_cycle();
    flush = 1'b0;
    drive(rd_txn(0, 0), 1'b0);
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wre !== 1'b0) begin
      errors++;
      $display("FAIL flush_post: valid=%b ready=%b wre=%b, required 0 1 0", out_valid, in_ready, out_wre);
    end
    for (int c = 0; c < 3; c++) begin
      clock_cycle();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost_%0d: out_valid=%b rd=%0d, required valid 0", c, out_valid, out_rd);
      end
    end
    $display("test_flush done");
  endtask

  task automatic test_bubble_gating();
    txn_t t;
    logic [VW-1:0] pat;
    do_reset();
    pat = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    t = rd_txn(6, 6);
    t.wre = 1'b1; t.vwre = 1'b1; t.vmem = pat; t.cvec = ~pat;
    drive(t, 1'b0);
    clock_cycle();
    checks++;
    if (out_valid !== 1'b0 || out_wre !== 1'b0 || out_vwre !== 1'b0) begin
      errors++;
      $display("FAIL bubble_idle: valid=%b wre=%b vwre=%b, required 0 0 0", out_valid, out_wre, out_vwre);
    end
    drive(t, 1'b1);
    clock_cycle();
    checks++;
    if (out_valid !== 1'b1 || out_wre !== 1'b1 || out_vwre !== 1'b1 ||
        out_vmem_data !== pat || out_calc_vec !== ~pat) begin
      errors++;
      $display("FAIL vector_exact: valid=%b wre=%b vwre=%b vmem=%h cvec=%h, required 1 1 1 %h %h",
               out_valid, out_wre, out_vwre, out_vmem_data, out_calc_vec, pat, ~pat);
    end
    out_ready = 1'b1;
    drive(t, 1'b0);
    clock_cycle();
    checks++;
    if (out_valid !== 1'b0 || out_wre !== 1'b0 || out_vwre !== 1'b0) begin
      errors++;
      $display("FAIL bubble_after_pop: valid=%b wre=%b vwre=%b, required 0 0 0", out_valid, out_wre, out_vwre);
    end
    $display("test_bubble_gating done");
  endtask

  task automatic test_stall_counter();
    do_reset();
    drive(rd_txn(2, 2), 1'b1);
    clock_cycle();
    drive(rd_txn(0, 0), 1'b0);
    for (int c = 0; c < 5; c++) clock_cycle();
    checks++;
    if (stall_cnt !== 16'(CNT_EN ? 5 : 0)) begin
      errors++;
      $display("FAIL stall_5: stall_cnt=%0d, required %0d", stall_cnt, CNT_EN ? 5 : 0);
    end
    flush = 1'b1;
    clock_cycle();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 16'(exp_stall())) begin
      errors++;
      $display("FAIL stall_flush_keep: stall_cnt=%0d, required %0d", stall_cnt, exp_stall());
    end
    if (CNT_EN) begin
      drive(rd_txn(1, 1), 1'b1);
      clock_cycle();
      drive(rd_txn(0, 0), 1'b0);
      for (int c = 0; c < 70000; c++) clock_cycle();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL stall_saturate: stall_cnt=%h, required ffff", stall_cnt);
      end
    end
    $display("test_stall_counter done");
  endtask

  task automatic test_random();
    txn_t t;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      t = rand_txn();
      drive(t, 1'($urandom_range(0, 99) < 70));
      out_ready = 1'($urandom_range(0, 99) < 60);
      flush = 1'($urandom_range(0, 99) < 4);
      checks++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2) ||
          stall_cnt !== 16'(exp_stall())) begin
        errors++;
        $display("FAIL rand_flags_%0d: valid=%b ready=%b stall=%0d, required %b %b %0d", c,
                 out_valid, in_ready, stall_cnt, model_q.size() > 0, model_q.size() < 2, exp_stall());
      end
      if (model_q.size() > 0) begin
        checks++;
        if (out_bus !== exp_bus(model_q[0]) || out_wre !== model_q[0].wre || out_vwre !== model_q[0].vwre) begin
          errors++;
          $display("FAIL rand_head_%0d: rd=%0d calc=%h wre=%b vwre=%b, required rd=%0d calc=%h wre=%b vwre=%b",
                   c, out_rd, out_calc_data, out_wre, out_vwre,
                   model_q[0].rd, model_q[0].calc, model_q[0].wre, model_q[0].vwre);
        end
      end else begin
        checks++;
        if (out_wre !== 1'b0 || out_vwre !== 1'b0) begin
          errors++;
          $display("FAIL rand_bubble_%0d: wre=%b vwre=%b, required 0 0", c, out_wre, out_vwre);
        end
      end
      clock_cycle();
    end
    flush = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_bubble_gating();
    test_stall_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
